// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and constants for the 8-way round-robin mux arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // One-hot vector with only bit idx set.
  function automatic req_vec_t onehot(input sel_t idx);
    req_vec_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Index following idx, wrapping 7 -> 0 through the natural 3-bit overflow.
  function automatic sel_t next_idx(input sel_t idx);
    return idx + sel_t'(1);
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Bus bundle between the requesters and the arbiter/mux.
//
// Handshake: requester i holds req[i] high for the whole burst. While i owns
// the mux (gnt[i]=1), every cycle with req[i]=1 is an accepted beat carrying
// din[i]; last[i]=1 in such a cycle marks that beat as the final one. The beat
// shows up on dout with dout_vld=1 one cycle later. Dropping req[i] while
// owning ends the burst without a beat. req/last/din of non-owners are ignored
// until they win arbitration.
interface mux8_rr_arbiter_if;
  import mux_arb_pkg::*;

  req_vec_t   req;
  req_vec_t   last;
  req_vec_t   din;
  req_vec_t   gnt;
  sel_t       sel;
  logic       busy;
  logic       dout;
  logic       dout_vld;

  // Internal state made visible for checkers.
  arb_state_t state_dbg;
  sel_t       ptr_dbg;
  cnt_t       hold_cnt_dbg;

  modport master (
    output req, last, din,
    input  gnt, sel, busy, dout, dout_vld, state_dbg, ptr_dbg, hold_cnt_dbg
  );

  modport slave (
    input  req, last, din,
    output gnt, sel, busy, dout, dout_vld, state_dbg, ptr_dbg, hold_cnt_dbg
  );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Rotating priority encoder: finds the first set request at or after ptr,
// wrapping from 7 back to 0.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  req_vec_t req,
  input  sel_t     ptr,
  output sel_t     idx,
  output logic     found
);

  // Scan from the farthest offset toward ptr so the nearest hit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[ptr + sel_t'(i)]) begin
        idx   = ptr + sel_t'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and sequencer for a shared 8:1 single-bit mux path.
// Grants one requester at a time, holds the grant for a burst, and registers
// the selected data bit. Every release is followed by one idle cycle.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16  // legal range 1..255
) (
  input  logic                clk,
  input  logic                rst_n,
  mux8_rr_arbiter_if.slave    bus
);

  localparam cnt_t MAX_HOLD_C = cnt_t'(MAX_HOLD);

  arb_state_t state_q, state_d;
  req_vec_t   gnt_q, gnt_d;
  sel_t       sel_q, sel_d;
  sel_t       ptr_q, ptr_d;
  cnt_t       hold_cnt_q, hold_cnt_d;
  logic       busy_q, busy_d;
  logic       dout_q, dout_d;
  logic       dout_vld_q, dout_vld_d;

  sel_t       pick_idx;
  logic       pick_found;
  logic       own_req;
  logic       own_last;
  logic       at_limit;
  logic       release_now;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Owner-side view of the bus; only meaningful while in OWN.
  assign own_req     = bus.req[sel_q];
  assign own_last    = bus.last[sel_q];
  assign at_limit    = (hold_cnt_q == MAX_HOLD_C);
  // Last beat, request drop and timeout all collapse into one release.
  assign release_now = !own_req || own_last || at_limit;

  // Next-state and next-output logic for the IDLE/OWN sequencer.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sel_d      = sel_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    busy_d     = busy_q;
    dout_d     = dout_q;
    dout_vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = OWN;
          gnt_d      = onehot(pick_idx);
          sel_d      = pick_idx;
          busy_d     = 1'b1;
          hold_cnt_d = cnt_t'(1);
        end
      end

      OWN: begin
        if (own_req) begin
          dout_d     = bus.din[sel_q];
          dout_vld_d = 1'b1;
        end
        if (release_now) begin
          state_d    = IDLE;
          gnt_d      = '0;
          busy_d     = 1'b0;
          // Moving past the owner gives it lowest priority next time.
          ptr_d      = next_idx(sel_q);
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + cnt_t'(1);
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      dout_q     <= 1'b0;
      dout_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      dout_q     <= dout_d;
      dout_vld_q <= dout_vld_d;
    end
  end

  assign bus.gnt          = gnt_q;
  assign bus.sel          = sel_q;
  assign bus.busy         = busy_q;
  assign bus.dout         = dout_q;
  assign bus.dout_vld     = dout_vld_q;
  assign bus.state_dbg    = state_q;
  assign bus.ptr_dbg      = ptr_q;
  assign bus.hold_cnt_dbg = hold_cnt_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Testbench for mux8_rr_arbiter: directed scenarios plus randomized traffic
// checked against a burst-level reference model.
module tb_mux8_rr_arbiter;
  import mux_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mux8_rr_arbiter_if bus ();
  mux8_rr_arbiter_if bus1 ();

  assign bus1.req  = bus.req;
  assign bus1.last = bus.last;
  assign bus1.din  = bus.din;

  mux8_rr_arbiter #(.MAX_HOLD(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mux8_rr_arbiter #(.MAX_HOLD(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // Index 0 models dut (MAX_HOLD=16), index 1 models dut1 (MAX_HOLD=1).
  int   m_owner[2];   // -1 when nobody owns the mux
  int   m_ptr[2];
  int   m_sel[2];
  int   m_cnt[2];     // OWN cycles consumed by the current grant
  logic m_vld[2];
  logic m_dout[2];
  int   m_hmax[2] = '{16, 1};
  logic [0:0] exp_q[$];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_owner[u] = -1;
      m_ptr[u]   = 0;
      m_sel[u]   = 0;
      m_cnt[u]   = 0;
      m_vld[u]   = 1'b0;
      m_dout[u]  = 1'b0;
    end
    exp_q.delete();
  endtask

  task automatic model_update(input logic [7:0] r, input logic [7:0] l, input logic [7:0] d);
    int o;
    for (int u = 0; u < 2; u++) begin
      if (m_owner[u] < 0) begin
        m_vld[u] = 1'b0;
        for (int j = 0; j < 8; j++) begin
          o = (m_ptr[u] + j) % 8;
          if (r[o] && m_owner[u] < 0) begin
            m_owner[u] = o;
            m_sel[u]   = o;
            m_cnt[u]   = 0;
          end
        end
      end else begin
        o = m_owner[u];
        m_cnt[u]++;
        if (r[o]) begin
          m_vld[u]  = 1'b1;
          m_dout[u] = d[o];
          if (u == 0) exp_q.push_back(d[o]);
        end else begin
          m_vld[u] = 1'b0;
        end
        if (!r[o] || l[o] || m_cnt[u] >= m_hmax[u]) begin
          m_owner[u] = -1;
          m_ptr[u]   = (o + 1) % 8;
        end
      end
    end
  endtask

  function automatic logic [7:0] m_gnt(input int u);
    return (m_owner[u] < 0) ? 8'h00 : 8'(1 << m_owner[u]);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input logic [7:0] r, input logic [7:0] l, input logic [7:0] d);
    @(negedge clk);
    bus.req  = r;
    bus.last = l;
    bus.din  = d;
    @(posedge clk);
    model_update(r, l, d);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.last = '0;
    bus.din  = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.req  = '0;
    bus.last = '0;
    bus.din  = '0;
    rst_n    = 1'b0;
    model_reset();
    #12;
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt got=%h exp=00", bus.gnt); end
    n_tests++; if (bus.sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.dout !== 1'b0) begin n_fail++; $display("FAIL reset_dout got=%b exp=0", bus.dout); end
    n_tests++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%b exp=0", bus.dout_vld); end
    n_tests++; if (bus.state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state got=%b exp=IDLE", bus.state_dbg); end
    n_tests++; if (bus.ptr_dbg !== 3'd0) begin n_fail++; $display("FAIL reset_ptr got=%0d exp=0", bus.ptr_dbg); end
    n_tests++; if (bus.hold_cnt_dbg !== 8'd0) begin n_fail++; $display("FAIL reset_hold got=%0d exp=0", bus.hold_cnt_dbg); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_burst();
    logic [7:0] dv;
    do_reset();
    step(8'h08, 8'h00, 8'($urandom));
    n_tests++; if (bus.gnt !== 8'h08) begin n_fail++; $display("FAIL burst_gnt got=%h exp=08", bus.gnt); end
    n_tests++; if (bus.sel !== 3'd3) begin n_fail++; $display("FAIL burst_sel got=%0d exp=3", bus.sel); end
    for (int i = 0; i < 4; i++) begin
      dv = 8'($urandom);
      step(8'h08, (i == 3) ? 8'h08 : 8'h00, dv);
      n_tests++; if (bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL burst_vld beat=%0d got=%b exp=1", i, bus.dout_vld); end
      n_tests++; if (bus.dout !== dv[3]) begin n_fail++; $display("FAIL burst_dout beat=%0d got=%b exp=%b", i, bus.dout, dv[3]); end
      n_tests++;
      if (bus.gnt !== ((i == 3) ? 8'h00 : 8'h08)) begin
        n_fail++; $display("FAIL burst_hold beat=%0d got=%h exp=%h", i, bus.gnt, (i == 3) ? 8'h00 : 8'h08);
      end
    end
    n_tests++; if (bus.ptr_dbg !== 3'd4) begin n_fail++; $display("FAIL burst_ptr got=%0d exp=4", bus.ptr_dbg); end
    step(8'h00, 8'h00, 8'h00);
    n_tests++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL burst_after_vld got=%b exp=0", bus.dout_vld); end
  endtask

  task automatic test_round_robin();
    int k;
    do_reset();
    step(8'hFF, 8'h00, 8'($urandom));
    for (int g = 0; g < 9; g++) begin
      k = g % 8;
      n_tests++; if (bus.gnt !== 8'(1 << k)) begin n_fail++; $display("FAIL rr_order g=%0d got=%h exp=%h", g, bus.gnt, 8'(1 << k)); end
      n_tests++; if ($countones(bus.gnt) > 1) begin n_fail++; $display("FAIL rr_onehot g=%0d got=%h exp=onehot", g, bus.gnt); end
      step(8'hFF, 8'(1 << k), 8'($urandom));
      n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL rr_idle g=%0d got=%h exp=00", g, bus.gnt); end
      n_tests++; if (bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL rr_beat g=%0d got=%b exp=1", g, bus.dout_vld); end
      if (g < 8) step(8'hFF, 8'h00, 8'($urandom));
    end
  endtask

  task automatic test_ptr_wrap();
    do_reset();
    step(8'h10, 8'h00, 8'h00);
    step(8'h10, 8'h10, 8'h00);
    n_tests++; if (bus.ptr_dbg !== 3'd5) begin n_fail++; $display("FAIL ptr_setup got=%0d exp=5", bus.ptr_dbg); end
    step(8'h44, 8'h00, 8'h00);
    n_tests++; if (bus.gnt !== 8'h40) begin n_fail++; $display("FAIL ptr_first got=%h exp=40", bus.gnt); end
    step(8'h44, 8'h40, 8'h00);
    step(8'h04, 8'h00, 8'h00);
    n_tests++; if (bus.gnt !== 8'h04) begin n_fail++; $display("FAIL ptr_second got=%h exp=04", bus.gnt); end
    step(8'h04, 8'h04, 8'h00);
    n_tests++; if (bus.ptr_dbg !== 3'd3) begin n_fail++; $display("FAIL ptr_end got=%0d exp=3", bus.ptr_dbg); end
  endtask

  task automatic test_hold_timeout();
    int beats;
    do_reset();
    step(8'h02, 8'h00, 8'($urandom));
    n_tests++; if (bus.gnt !== 8'h02) begin n_fail++; $display("FAIL to_grant got=%h exp=02", bus.gnt); end
    beats = 0;
    for (int i = 1; i <= 16; i++) begin
      step(8'h02, 8'h00, 8'($urandom));
      if (bus.dout_vld === 1'b1) beats++;
      n_tests++;
      if (bus.gnt !== ((i == 16) ? 8'h00 : 8'h02)) begin
        n_fail++; $display("FAIL to_hold cyc=%0d got=%h exp=%h", i, bus.gnt, (i == 16) ? 8'h00 : 8'h02);
      end
    end
    n_tests++; if (beats !== 16) begin n_fail++; $display("FAIL to_beats got=%0d exp=16", beats); end
    step(8'h02, 8'h00, 8'h00);
    n_tests++; if (bus.gnt !== 8'h02) begin n_fail++; $display("FAIL to_regrant got=%h exp=02", bus.gnt); end
    for (int i = 1; i <= 16; i++) step(8'h02, 8'h00, 8'h00);
    step(8'h06, 8'h00, 8'h00);
    n_tests++; if (bus.gnt !== 8'h04) begin n_fail++; $display("FAIL to_other got=%h exp=04", bus.gnt); end
  endtask

  task automatic test_req_drop();
    do_reset();
    step(8'h04, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(8'h04, 8'h00, 8'($urandom));
      n_tests++; if (bus.dout_vld !== 1'b1) begin n_fail++; $display("FAIL drop_beat i=%0d got=%b exp=1", i, bus.dout_vld); end
    end
    step(8'h00, 8'h00, 8'hFF);
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL drop_gnt got=%h exp=00", bus.gnt); end
    n_tests++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL drop_vld got=%b exp=0", bus.dout_vld); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL drop_busy got=%b exp=0", bus.busy); end
    step(8'h00, 8'h00, 8'hFF);
    n_tests++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL drop_vld2 got=%b exp=0", bus.dout_vld); end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(8'h20, 8'h00, 8'h00);
    step(8'h20, 8'h20, 8'h00);
    step(8'h20, 8'h00, 8'h00);
    step(8'h20, 8'h00, 8'hFF);
    step(8'h20, 8'h00, 8'hFF);
    #2;
    rst_n    = 1'b0;
    bus.req  = '0;
    bus.last = '0;
    bus.din  = '0;
    #1;
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL arst_gnt got=%h exp=00", bus.gnt); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
    n_tests++; if (bus.dout_vld !== 1'b0) begin n_fail++; $display("FAIL arst_vld got=%b exp=0", bus.dout_vld); end
    n_tests++; if (bus.sel !== 3'd0) begin n_fail++; $display("FAIL arst_sel got=%0d exp=0", bus.sel); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++; if (bus.ptr_dbg !== 3'd0) begin n_fail++; $display("FAIL arst_ptr got=%0d exp=0", bus.ptr_dbg); end
    step(8'h81, 8'h00, 8'h00);
    n_tests++; if (bus.gnt !== 8'h01) begin n_fail++; $display("FAIL arst_restart got=%h exp=01", bus.gnt); end
  endtask

  task automatic test_random();
    logic [7:0] r, l, d;
    logic [0:0] e;
    do_reset();
    r = 8'($urandom);
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      l = 8'($urandom & $urandom & $urandom);
      d = 8'($urandom);
      step(r, l, d);
      n_tests++; if (bus.gnt !== m_gnt(0)) begin n_fail++; $display("FAIL rand_gnt c=%0d got=%h exp=%h", c, bus.gnt, m_gnt(0)); end
      n_tests++; if (bus.sel !== 3'(m_sel[0])) begin n_fail++; $display("FAIL rand_sel c=%0d got=%0d exp=%0d", c, bus.sel, m_sel[0]); end
      n_tests++; if (bus.busy !== (m_owner[0] >= 0)) begin n_fail++; $display("FAIL rand_busy c=%0d got=%b exp=%b", c, bus.busy, m_owner[0] >= 0); end
      n_tests++; if (bus.dout_vld !== m_vld[0]) begin n_fail++; $display("FAIL rand_vld c=%0d got=%b exp=%b", c, bus.dout_vld, m_vld[0]); end
      n_tests++; if (bus.ptr_dbg !== 3'(m_ptr[0])) begin n_fail++; $display("FAIL rand_ptr c=%0d got=%0d exp=%0d", c, bus.ptr_dbg, m_ptr[0]); end
      if (bus.dout_vld === 1'b1) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_dout c=%0d got=%b exp=none", c, bus.dout);
        end else begin
          e = exp_q.pop_front();
          if (bus.dout !== e[0]) begin n_fail++; $display("FAIL rand_dout c=%0d got=%b exp=%b", c, bus.dout, e[0]); end
        end
      end
    end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_max_hold_one();
    int grants, beats;
    logic [7:0] r, d;
    do_reset();
    grants = 0;
    beats  = 0;
    for (int c = 0; c < 48; c++) begin
      step(8'hFF, 8'h00, 8'($urandom));
      if (bus1.gnt !== 8'h00) grants++;
      if (bus1.dout_vld === 1'b1) beats++;
    end
    n_tests++; if (grants !== 24) begin n_fail++; $display("FAIL mh1_grants got=%0d exp=24", grants); end
    n_tests++; if (beats !== 24) begin n_fail++; $display("FAIL mh1_beats got=%0d exp=24", beats); end
    r = 8'($urandom);
    for (int c = 0; c < 150; c++) begin
      for (int b = 0; b < 8; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      d = 8'($urandom);
      step(r, 8'h00, d);
      n_tests++; if (bus1.gnt !== m_gnt(1)) begin n_fail++; $display("FAIL mh1_gnt c=%0d got=%h exp=%h", c, bus1.gnt, m_gnt(1)); end
      n_tests++; if (bus1.dout_vld !== m_vld[1]) begin n_fail++; $display("FAIL mh1_vld c=%0d got=%b exp=%b", c, bus1.dout_vld, m_vld[1]); end
      if (m_vld[1]) begin
        n_tests++; if (bus1.dout !== m_dout[1]) begin n_fail++; $display("FAIL mh1_dout c=%0d got=%b exp=%b", c, bus1.dout, m_dout[1]); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_ptr_wrap();
    test_hold_timeout();
    test_req_drop();
    test_async_reset();
    test_random();
    test_max_hold_one();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
Round-robin arbiter and sequencer that shares one 8:1 single-bit mux path between 8 requesters. It grants one requester at a time, drives the 3-bit mux select, and holds the grant for a burst of serial bits. It releases on end-of-burst, request drop or hold timeout. It sits in front of the 8:1 multiplexer datapath and also registers the selected output bit.

Parameters:
MAX_HOLD, 16, max cycles one grant may be held in OWN before forced release; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  8  per-requester request; must stay high for the whole burst
last  input  8  per-requester end-of-burst marker; qualifies that cycle's bit
din  input  8  per-requester serial data bit
gnt  output  8  one-hot grant, or all zero
sel  output  3  mux select, equal to the current or most recent owner index
busy  output  1  high while state is OWN
dout  output  1  registered selected data bit
dout_vld  output  1  dout holds an accepted beat

Behaviour:
- Reset (async assert, sync release): state IDLE, gnt=0, sel=0, busy=0, dout=0, dout_vld=0, ptr=0, hold_cnt=0.
- States: IDLE, OWN. All outputs are registered.
- IDLE:
  - If req!=0, pick the first set bit scanning ptr, ptr+1, ... mod 8. Wrap 7->0.
  - At the next edge: state=OWN, gnt=onehot(winner), sel=winner, busy=1, hold_cnt=1.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req==0, stay in IDLE; sel keeps its last value.
- OWN:
  - A beat is accepted in any cycle where req[sel]=1. Next edge: dout=din[sel], dout_vld=1.
  - In any other cycle, dout_vld=0 at the next edge and dout holds its value.
  - Release conditions, evaluated each OWN cycle:
    - (a) req[sel]=1 and last[sel]=1: beat accepted, then release.
    - (b) req[sel]=0: no beat, release.
    - (c) hold_cnt==MAX_HOLD: beat accepted if req high, forced release.
  - Otherwise hold_cnt increments.
  - On release, at the next edge: state=IDLE, gnt=0, busy=0, ptr=(sel+1) mod 8.
  - Every release is followed by exactly one IDLE cycle with gnt=0; there is no back-to-back handoff.
- Simultaneous events:
  - Requests from non-owners during OWN wait; they do not affect the current grant.
  - last from non-owners is ignored.
  - (a) and (c) in the same cycle count as a single release.
  - The owner re-requesting right after release has lowest priority for that arbitration, because ptr has moved past it.
- hold_cnt width: 8 bits; it never exceeds MAX_HOLD.
- Reset mid-burst: immediate return to reset values. The partial burst is discarded with no further dout_vld.
- MAX_HOLD=1: every grant carries exactly one beat.

Decomposition:
- Package mux_arb_pkg holds:
  - NUM_REQ=8
  - SEL_W=3
  - typedef enum logic {IDLE, OWN} arb_state_t
  - typedef logic [SEL_W-1:0] sel_t
- One combinational sub-module, rr_pick8:
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: idx[2:0], found.
  - Function: rotating priority encoder.
- The top level holds the FSM, ptr, hold_cnt and the output registers.

Test Plan:
1. Reset, then req=8'h08 held from cycle 0, last[3] on the 4th beat. Required: gnt=8'h08 and sel=3 after edge 1; dout_vld high for 4 cycles carrying din[3]; gnt=0 one cycle after the last beat; ptr=4.
2. req=8'hFF held constantly, last pulsed on each owner's 1st beat. Required: grant order 0,1,2,...,7,0 with one IDLE cycle between grants; gnt never has more than one bit set.
3. ptr=5 (reached via a prior grant to 4), then req=8'h44. Required: requester 6 granted first, then 2 after its release; ptr ends at 3.
4. MAX_HOLD=16, req[1] held, last never asserted. Required: exactly 16 dout_vld beats; forced release; req[1] still high is regranted after one IDLE cycle only if no other request is pending.
5. Owner 2 drops req mid-burst after 3 beats. Required: 3 beats delivered; gnt=0 at the next edge; no 4th dout_vld.
6. rst_n asserted low mid-burst, asynchronously between clock edges. Required: gnt, busy, dout_vld and sel go to 0 immediately, without a clock edge; after release, arbitration restarts from ptr=0.
